overlay_text_ctrl: RTL and testbench
====================================

OVERLAY_TEXT_CTRL -- requirements
Module: overlay_text_ctrl

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 192: left pixel column of the text row.
REQ-002 SHALL have parameter ORIGIN_Y, default 936: top pixel line of the text row.
REQ-003 SHALL have parameter CHARS, default 16, legal range 1-16: number of character slots.
REQ-004 SHALL have port CLOCK  input  1  pixel clock, the only clock.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port VGA_horzCoord  input  12  current pixel column.
REQ-007 SHALL have port VGA_vertCoord  input  12  current pixel line.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse per frame, issued during vertical blank.
REQ-009 SHALL have port wr_en  input  1  shadow-buffer write request.
REQ-010 SHALL have port wr_addr  input  4  slot index.
REQ-011 SHALL have port wr_data  input  4  glyph code.
REQ-012 SHALL have port wr_ready  output  1  write accepted when wr_en and wr_ready are both high.
REQ-013 SHALL have port commit  input  1  one-cycle request to publish the shadow buffer.
REQ-014 SHALL have port commit_done  output  1  one-cycle pulse when a publish completes.
REQ-015 SHALL have port overlay_on  output  1  high when the pixel is a lit glyph pixel.

Function
REQ-016 SHALL hold two CHARS x 4-bit buffers: shadow (host-written) and active (rendered).
REQ-017 SHALL ignore accepted writes with wr_addr >= CHARS.
REQ-018 SHALL decode glyph codes 0-9 as digits, 10 '/', 11 '.', 12 'V', 13 'm', 14 's', and 15 blank.
REQ-019 SHALL store each glyph as a 5x7 internal ROM bitmap, drawn at 2x scale (10x14 px) with a 12 px horizontal cell pitch.
REQ-020 SHALL draw the '/' glyph as a single diagonal rising from bottom-left to top-right.
REQ-021 SHALL bound the text region to x in [ORIGIN_X, ORIGIN_X+12*CHARS-1] and y in [ORIGIN_Y, ORIGIN_Y+13].
REQ-022 SHALL drive overlay_on to 0 outside the text region and in cell columns 10-11 (the inter-character gap).
REQ-023 SHALL register overlay_on with exactly 2 cycles of latency from the coordinates to the output (stage 1: slot/row/column decode; stage 2: ROM bit).
REQ-024 SHALL implement the FSM IDLE -> PENDING on commit; PENDING -> COPY on frame_start; COPY -> DONE after copying slots 0..CHARS-1, one slot per cycle; DONE -> IDLE after one cycle with commit_done=1.
REQ-025 SHALL hold wr_ready at 0 during COPY and DONE, and at 1 otherwise.
REQ-026 SHALL, when wr_en and commit occur in the same cycle, accept the write and include it in that publish.
REQ-027 SHALL treat commit during PENDING as a no-op; the pending request remains single.
REQ-028 SHALL latch a commit received during COPY or DONE and enter PENDING immediately after DONE.
REQ-029 SHALL ignore a frame_start that arrives during COPY.
REQ-030 SHALL render from the active buffer only, so that an active update never occurs outside vertical blank.
REQ-031 SHALL treat coordinate arithmetic as 12-bit unsigned; ORIGIN_X+12*CHARS and ORIGIN_Y+14 SHALL NOT exceed 4095 (parameter legality).

Reset
REQ-032 SHALL, on RESET, set both buffers to code 15 (blank) and the FSM to IDLE, clear the latched commit, set overlay_on=0, commit_done=0 and wr_ready=1.
REQ-033 SHALL, when RESET asserts mid-COPY, abort the copy and leave the active buffer fully blank.
REQ-034 SHALL clear the overlay_on pipeline stages on RESET, so that overlay_on=0 for 2 cycles after release.

Configuration
REQ-035 SHALL provide the macro OVERLAY_BLINK_EN.
REQ-036 SHALL, with OVERLAY_BLINK_EN defined, add a 5-bit frame counter; the blink phase SHALL toggle every 30 frame_start pulses and, while the phase is 1, slot CHARS-1 SHALL render blank. The counter and phase SHALL reset to 0.
REQ-037 SHALL, without OVERLAY_BLINK_EN, omit the counter and render all slots continuously.

Verification
REQ-038 Reset, then scan the full region -> overlay_on=0 everywhere.
REQ-039 Write slot 0=10, commit, frame_start, scan x=192..203, y=936..949 -> lit pixels form a rising diagonal; commit_done pulses 16 cycles after frame_start; overlay_on lags the coordinates by 2 cycles.
REQ-040 Write slot 3=7 without commit over 3 frames -> active buffer unchanged and slot 3 stays blank.
REQ-041 Commit during COPY -> wr_ready=0 for 17 cycles; FSM returns to PENDING after DONE; a second commit_done pulses after the next frame_start.
REQ-042 Assert RESET on copy cycle 5 -> all slots render blank; wr_ready=1 the cycle after release.
REQ-043 With OVERLAY_BLINK_EN, slot 15=8 -> slot 15 is blank for frames 30-59, visible for frames 0-29 and 60-89.

Source files
------------

// File: rtl/overlay_text_ctrl.sv
// overlay_text_ctrl -- one row of up to 16 glyphs drawn over a video stream.
//
// The host fills a shadow buffer through the wr_* port and requests a publish
// with commit. The publish waits for the next frame_start (vertical blank).
// It then copies the shadow buffer into the active buffer, one slot per
// clock. The renderer only ever reads the active buffer, so the visible text
// never tears mid-frame.
//
// Parameters:
//   ORIGIN_X, ORIGIN_Y : top-left pixel of the text row
//   CHARS              : number of character slots (1..16)
// Ports:
//   CLOCK, RESET        : pixel clock, synchronous active-high reset
//   VGA_horzCoord/vertCoord : current pixel coordinates (12-bit)
//   frame_start         : one-cycle pulse per frame in vertical blank
//   wr_en/wr_addr/wr_data, wr_ready : shadow-buffer write port
//   commit, commit_done : publish request / completion pulse
//   overlay_on          : lit glyph pixel, 2 cycles after the coordinates
// Optional build macro:
//   OVERLAY_BLINK_EN : blink the last slot with a 30-frame on/off period
module overlay_text_ctrl #(
  parameter int ORIGIN_X = 192,
  parameter int ORIGIN_Y = 936,
  parameter int CHARS    = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [11:0] VGA_horzCoord,
  input  logic [11:0] VGA_vertCoord,
  input  logic        frame_start,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic        wr_ready,
  input  logic        commit,
  output logic        commit_done,
  output logic        overlay_on
);

  localparam logic [11:0] X_LO  = 12'(ORIGIN_X);
  localparam logic [11:0] X_HI  = 12'(ORIGIN_X + 12 * CHARS - 1);
  localparam logic [11:0] Y_LO  = 12'(ORIGIN_Y);
  localparam logic [11:0] Y_HI  = 12'(ORIGIN_Y + 13);
  localparam logic [3:0]  LAST  = 4'(CHARS - 1);
  localparam logic [3:0]  BLANK = 4'd15;

  typedef enum logic [1:0] {IDLE, PENDING, COPY, DONE} state_t;

  state_t     state;
  logic [3:0] shadow [CHARS];
  logic [3:0] active [CHARS];
  logic [3:0] copy_idx;
  logic       commit_pend;

  // 5x7 font, top row in the MSBs, leftmost pixel in the MSB of each row.
  function automatic logic [4:0] glyph_row(input logic [3:0] code, input logic [2:0] row);
    logic [34:0] g;
    logic [34:0] s;
    case (code)
      4'd0:    g = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1:    g = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2:    g = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3:    g = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4:    g = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5:    g = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6:    g = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7:    g = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8:    g = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9:    g = 35'b01110_10001_10001_01111_00001_00010_01100;
      4'd10:   g = 35'b00001_00010_00010_00100_01000_01000_10000; // '/'
      4'd11:   g = 35'b00000_00000_00000_00000_00000_01100_01100; // '.'
      4'd12:   g = 35'b10001_10001_10001_10001_10001_01010_00100; // 'V'
      4'd13:   g = 35'b00000_00000_11010_10101_10101_10101_10101; // 'm'
      4'd14:   g = 35'b00000_00000_01111_10000_01110_00001_11110; // 's'
      default: g = '0;                                            // blank
    endcase
    s = g << ({3'b000, row} * 6'd5);
    return s[34:30];
  endfunction

  // Publish FSM and both character buffers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      copy_idx    <= '0;
      commit_pend <= 1'b0;
      wr_ready    <= 1'b1;
      commit_done <= 1'b0;
      for (int i = 0; i < CHARS; i++) begin
        shadow[i] <= BLANK;
        active[i] <= BLANK;
      end
    end else begin
      commit_done <= 1'b0;
      if (wr_en && wr_ready && (int'(wr_addr) < CHARS))
        shadow[wr_addr] <= wr_data;
      case (state)
        IDLE:
          if (commit) state <= PENDING;
        PENDING:
          // A repeated commit here is absorbed: one publish is already queued.
          if (frame_start) begin
            state    <= COPY;
            copy_idx <= '0;
            wr_ready <= 1'b0;
          end
        COPY: begin
          active[copy_idx] <= shadow[copy_idx];
          if (commit) commit_pend <= 1'b1;
          if (copy_idx == LAST) begin
            state       <= DONE;
            commit_done <= 1'b1;
          end else begin
            copy_idx <= copy_idx + 4'd1;
          end
        end
        DONE: begin
          wr_ready    <= 1'b1;
          commit_pend <= 1'b0;
          state       <= (commit_pend || commit) ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last-slot blanking for the blink option.
  logic hide;
`ifdef OVERLAY_BLINK_EN
  logic [4:0] frame_cnt;
  logic       blink_phase;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == 5'd29) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end
`endif

  // Stage 0 -> 1: coordinate decode into slot, glyph row and glyph column.
  logic [11:0] dx, dy;
  logic [3:0]  slot_c, ccol_c;
  logic        vld_c;
  always_comb begin
    dx     = VGA_horzCoord - X_LO;
    dy     = VGA_vertCoord - Y_LO;
    slot_c = 4'(dx / 12'd12);
    ccol_c = 4'(dx % 12'd12);
    // Cell columns 10-11 form the inter-character gap.
    vld_c  = (VGA_horzCoord >= X_LO) && (VGA_horzCoord <= X_HI) &&
             (VGA_vertCoord >= Y_LO) && (VGA_vertCoord <= Y_HI) &&
             (ccol_c < 4'd10);
  end

  logic       vld_p1;
  logic [3:0] slot_p1;
  logic [2:0] row_p1, gcol_p1;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
      row_p1  <= '0;
      gcol_p1 <= '0;
    end else begin
      vld_p1  <= vld_c;
      slot_p1 <= slot_c;
      row_p1  <= 3'(dy >> 1);
      gcol_p1 <= 3'(ccol_c >> 1);
    end
  end

  // Stage 1 -> 2: font ROM lookup on the active buffer.
  logic [4:0] bits_p1;
  logic       lit_p1;
  always_comb begin
`ifdef OVERLAY_BLINK_EN
    hide = blink_phase && (slot_p1 == LAST);
`else
    hide = 1'b0;
`endif
    bits_p1 = glyph_row(active[slot_p1], row_p1);
    lit_p1  = bits_p1[3'd4 - gcol_p1];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) overlay_on <= 1'b0;
    else       overlay_on <= vld_p1 && lit_p1 && !hide;
  end

endmodule

// File: tb/tb_overlay_text_ctrl.sv
// Self-checking bench for overlay_text_ctrl (default parameters).
// Expected pixels come from a bench-side model of the active buffer and font
// and are pushed to a queue when coordinates are driven. Each entry is popped
// two clocks later, when the DUT output for those coordinates should appear.
module tb_overlay_text_ctrl;
  localparam int OX = 192;
  localparam int OY = 936;
  localparam int CH = 16;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [11:0] VGA_horzCoord, VGA_vertCoord;
  logic        frame_start, wr_en, commit;
  logic [3:0]  wr_addr, wr_data;
  logic        wr_ready, commit_done, overlay_on;

  overlay_text_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .VGA_horzCoord(VGA_horzCoord), .VGA_vertCoord(VGA_vertCoord),
    .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .commit_done(commit_done),
    .overlay_on(overlay_on)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int fcount  = 0;
  int sh_m [CH];
  int act_m [CH];
  bit q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Glyph column (0 = left) lit in each row of '/', bottom-left to top-right.
  function automatic int slash_col(input int row);
    case (row)
      0:       return 4;
      1, 2:    return 3;
      3:       return 2;
      4, 5:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit font_px(input int code, input int row, input int gc);
    case (code)
      10: return gc == slash_col(row);
      8:  if (row == 0 || row == 3 || row == 6) return (gc >= 1 && gc <= 3);
          else return (gc == 0 || gc == 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_px(input int x, input int y);
    int dx, slot, cc;
    bit phase;
    if (x < OX || x > OX + 12 * CH - 1 || y < OY || y > OY + 13) return 1'b0;
    dx = x - OX;
    slot = dx / 12;
    cc = dx % 12;
    if (cc >= 10) return 1'b0;
`ifdef OVERLAY_BLINK_EN
    phase = ((fcount / 30) % 2) == 1;
`else
    phase = 1'b0;
`endif
    if (phase && slot == CH - 1) return 1'b0;
    return font_px(act_m[slot], (y - OY) / 2, cc / 2);
  endfunction

  task automatic px_step(input int x, input int y);
    VGA_horzCoord = 12'(x);
    VGA_vertCoord = 12'(y);
    q.push_back(exp_px(x, y));
    tick();
    if (q.size() == 2) chk("pix", int'(overlay_on), int'(q.pop_front()));
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    q.delete();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        px_step(x, y);
    px_step(0, 0);
    q.delete();
  endtask

  task automatic wr(input int a, input int d, input bit c);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d); commit = c;
    sh_m[a] = d;
    tick();
    wr_en = 1'b0; commit = 1'b0;
  endtask

  // Pulse frame_start with a publish pending and follow the copy. If inj >= 0,
  // a commit plus a write attempt go in on copy cycle inj and a stray
  // frame_start two cycles later.
  task automatic publish(input int inj);
    int n, lows;
    frame_start = 1'b1; fcount++;
    tick();
    frame_start = 1'b0;
    n = 0; lows = 0;
    while (n < 40 && !commit_done) begin
      if (!wr_ready) lows++;
      if (inj >= 0 && n == inj) begin
        commit = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'd8;
      end
      if (inj >= 0 && n == inj + 2) begin frame_start = 1'b1; fcount++; end
      tick();
      commit = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
      n++;
    end
    if (!wr_ready) lows++;
    chk("done_latency", n, 16);
    chk("ready_low_cycles", lows, 17);
    for (int i = 0; i < CH; i++) act_m[i] = sh_m[i];
    tick();
    chk("done_one_cycle", int'(commit_done), 0);
    chk("ready_after_done", int'(wr_ready), 1);
  endtask

  task automatic count_done(input int cycles, input bit fs, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (fs && i == 3) begin frame_start = 1'b1; fcount++; end
      tick();
      frame_start = 1'b0;
      if (commit_done) pulses++;
    end
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1; fcount++;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    fcount = 0;
    for (int i = 0; i < CH; i++) begin sh_m[i] = 15; act_m[i] = 15; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int targets [6] = '{1, 29, 30, 59, 60, 89};
    RESET = 1'b1; frame_start = 1'b0; wr_en = 1'b0; commit = 1'b0;
    wr_addr = '0; wr_data = '0;
    VGA_horzCoord = 12'(OX + 1); VGA_vertCoord = 12'(OY + 1);
    tick(); tick();
    do_reset();
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_commit_done", int'(commit_done), 0);
    chk("rst_overlay", int'(overlay_on), 0);
    tick();
    chk("rst_overlay_2", int'(overlay_on), 0);

    // Blank after reset across the whole region and its border.
    scan(OX - 2, OX + 12 * CH + 1, OY - 1, OY + 14);

    // Slot 0 = '/', written in the same cycle as commit.
    wr(0, 10, 1'b1);
    count_done(5, 1'b0, p);
    chk("pending_no_done", p, 0);
    chk("pending_ready", int'(wr_ready), 1);
    publish(-1);
    scan(OX - 2, OX + 13, OY - 1, OY + 14);

    // Uncommitted write never reaches the display across 3 frames.
    wr(3, 7, 1'b0);
    count_done(10, 1'b1, p);
    chk("no_commit_f1", p, 0);
    count_done(10, 1'b1, p);
    chk("no_commit_f2", p, 0);
    count_done(10, 1'b1, p);
    chk("no_commit_f3", p, 0);
    scan(OX, OX + 12 * 5 - 1, OY, OY + 13);

    // Commit during COPY re-queues exactly one further publish.
    wr(3, 15, 1'b0);
    wr(1, 8, 1'b1);
    publish(4);
    count_done(20, 1'b0, p);
    chk("requeued_waits", p, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    wr(4, 8, 1'b0);
    publish(-1);
    count_done(40, 1'b1, p);
    chk("single_pending", p, 0);
    scan(OX - 2, OX + 12 * CH + 1, OY - 1, OY + 14);

    // Reset on copy cycle 5 leaves everything blank.
    wr(6, 8, 1'b1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    do_reset();
    chk("abort_ready", int'(wr_ready), 1);
    chk("abort_done", int'(commit_done), 0);
    tick();
    chk("abort_ready_2", int'(wr_ready), 1);
    scan(OX - 2, OX + 12 * CH + 1, OY - 1, OY + 14);

    // Last slot across the blink boundaries (always visible without blink).
    wr(CH - 1, 8, 1'b1);
    publish(-1);
    foreach (targets[k]) begin
      while (fcount < targets[k]) fs_pulse();
      scan(OX + 12 * (CH - 1), OX + 12 * CH - 1, OY, OY + 13);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
